// File: rtl/mem_port_arb_if.sv
// Bundle of the fetch, EX load/store and SRAM signals seen by the memory port arbiter.
// The slave modport is the arbiter's view; master is the pipeline/SRAM side.
interface mem_port_arb_if;
  logic        inst_req;
  logic [63:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_rvalid;
  logic        data_sram_en;
  logic [7:0]  data_sram_we;
  logic [63:0] data_sram_addr;
  logic [63:0] data_sram_wdata;
  logic [63:0] data_rdata;
  logic        data_rvalid;
  logic        flush;
  logic        mem_en;
  logic [7:0]  mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        stallreq_if;
  logic        stallreq_ex;

  modport slave (
    input  inst_req, inst_addr, data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    input  flush, mem_rdata,
    output inst_rdata, inst_rvalid, data_rdata, data_rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata, stallreq_if, stallreq_ex
  );

  modport master (
    output inst_req, inst_addr, data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    output flush, mem_rdata,
    input  inst_rdata, inst_rvalid, data_rdata, data_rvalid,
    input  mem_en, mem_we, mem_addr, mem_wdata, stallreq_if, stallreq_ex
  );
endinterface

// File: rtl/mem_port_arb.sv
// Arbiter for the single-ported unified SRAM shared by instruction fetch and EX load/store.
// Data has priority; a starvation counter forces fetch through after STARVE_MAX losses.
module mem_port_arb #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = 3
) (
  input logic           clk,
  input logic           rst_n,
  mem_port_arb_if.slave bus
);

  typedef enum logic [1:0] {OwnNone, OwnInst, OwnData} owner_e;

  localparam logic [CNT_W-1:0] StarveMax = CNT_W'(STARVE_MAX);

  owner_e           owner_q, owner_d;
  logic             lane_q, lane_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  logic inst_live;
  logic force_inst;
  logic grant_inst;
  logic grant_data;

  // A fetch in a flush cycle is on the wrong path: it neither competes nor stalls.
  assign inst_live  = bus.inst_req & ~bus.flush;
  assign force_inst = (starve_cnt_q == StarveMax);
  assign grant_data = bus.data_sram_en & ~(force_inst & inst_live);
  assign grant_inst = inst_live & ~grant_data;

  assign bus.stallreq_if = inst_live & ~grant_inst;
  assign bus.stallreq_ex = bus.data_sram_en & ~grant_data;

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 8'h00;
    bus.mem_addr  = 64'h0;
    bus.mem_wdata = 64'h0;
    if (grant_data) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.data_sram_we;
      bus.mem_addr  = bus.data_sram_addr;
      bus.mem_wdata = bus.data_sram_wdata;
    end else if (grant_inst) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = {bus.inst_addr[63:3], 3'b000};
    end
  end

  always_comb begin
    owner_d      = OwnNone;
    lane_d       = bus.inst_addr[2];
    starve_cnt_d = starve_cnt_q;
    if (grant_inst) begin
      owner_d = OwnInst;
    end else if (grant_data && (bus.data_sram_we == 8'h00)) begin
      owner_d = OwnData;
    end
    if (grant_inst || !bus.inst_req || bus.flush) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != StarveMax) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q      <= OwnNone;
      lane_q       <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      owner_q      <= owner_d;
      lane_q       <= lane_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // A flush in the response cycle kills a fetch response; loads always return.
  always_comb begin
    bus.inst_rvalid = 1'b0;
    bus.inst_rdata  = 32'h0;
    bus.data_rvalid = 1'b0;
    bus.data_rdata  = 64'h0;
    unique case (owner_q)
      OwnInst: begin
        if (!bus.flush) begin
          bus.inst_rvalid = 1'b1;
          bus.inst_rdata  = lane_q ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
        end
      end
      OwnData: begin
        bus.data_rvalid = 1'b1;
        bus.data_rdata  = bus.mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Scoreboard bench for mem_port_arb: expected responses are queued with their due cycle
// when a grant is driven, and a negedge monitor pops and compares them.
module tb_mem_port_arb;
  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc   = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    int unsigned cyc;
    logic [63:0] data;
  } exp_t;

  exp_t inst_q[$];
  exp_t data_q[$];
  exp_t mon_i, mon_d;

  mem_port_arb_if bus ();

  mem_port_arb #(.STARVE_MAX(4), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] pat(input int unsigned idx);
    if (idx == 0) return 64'hAAAA_BBBB_CCCC_DDDD;
    return {32'hC0DE_0000 + idx, 32'h5EED_0000 + idx};
  endfunction

  // SRAM model: one-cycle read latency, stores overwrite the whole word.
  logic [63:0]  sram [256];
  logic [255:0] written;
  logic [63:0]  rd_q;
  logic [7:0]   sidx;
  assign sidx = bus.mem_addr[10:3];
  assign bus.mem_rdata = rd_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written <= '0;
      rd_q    <= '0;
    end else if (bus.mem_en) begin
      if (bus.mem_we == 8'h00) begin
        rd_q <= written[sidx] ? sram[sidx] : pat(32'(sidx));
      end else begin
        sram[sidx]    <= bus.mem_wdata;
        written[sidx] <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      while (inst_q.size() > 0 && inst_q[0].cyc < cyc) begin
        mon_i = inst_q.pop_front();
        checks++; errors++;
        $display("FAIL inst_resp_missed due %0d got none want %h", mon_i.cyc, mon_i.data[31:0]);
      end
      checks++;
      if (inst_q.size() > 0 && inst_q[0].cyc == cyc) begin
        mon_i = inst_q.pop_front();
        if (bus.inst_rvalid !== 1'b1 || bus.inst_rdata !== mon_i.data[31:0]) begin
          errors++;
          $display("FAIL inst_resp cyc %0d got v=%b %h want v=1 %h", cyc, bus.inst_rvalid,
                   bus.inst_rdata, mon_i.data[31:0]);
        end
      end else if (bus.inst_rvalid !== 1'b0 || bus.inst_rdata !== 32'h0) begin
        errors++;
        $display("FAIL inst_idle cyc %0d got v=%b %h want v=0 0", cyc, bus.inst_rvalid,
                 bus.inst_rdata);
      end

      while (data_q.size() > 0 && data_q[0].cyc < cyc) begin
        mon_d = data_q.pop_front();
        checks++; errors++;
        $display("FAIL data_resp_missed due %0d got none want %h", mon_d.cyc, mon_d.data);
      end
      checks++;
      if (data_q.size() > 0 && data_q[0].cyc == cyc) begin
        mon_d = data_q.pop_front();
        if (bus.data_rvalid !== 1'b1 || bus.data_rdata !== mon_d.data) begin
          errors++;
          $display("FAIL data_resp cyc %0d got v=%b %h want v=1 %h", cyc, bus.data_rvalid,
                   bus.data_rdata, mon_d.data);
        end
      end else if (bus.data_rvalid !== 1'b0 || bus.data_rdata !== 64'h0) begin
        errors++;
        $display("FAIL data_idle cyc %0d got v=%b %h want v=0 0", cyc, bus.data_rvalid,
                 bus.data_rdata);
      end
    end
  end

  task automatic push_inst(input logic [31:0] d);
    exp_t e;
    e.cyc = cyc + 1;
    e.data = {32'h0, d};
    inst_q.push_back(e);
  endtask

  task automatic push_data(input logic [63:0] d);
    exp_t e;
    e.cyc = cyc + 1;
    e.data = d;
    data_q.push_back(e);
  endtask

  task automatic drive(input logic ireq, input logic [63:0] iaddr, input logic den,
                       input logic [7:0] dwe, input logic [63:0] daddr,
                       input logic [63:0] dwdata, input logic fl);
    bus.inst_req        = ireq;
    bus.inst_addr       = iaddr;
    bus.data_sram_en    = den;
    bus.data_sram_we    = dwe;
    bus.data_sram_addr  = daddr;
    bus.data_sram_wdata = dwdata;
    bus.flush           = fl;
  endtask

  task automatic idle();
    drive(1'b0, 64'h0, 1'b0, 8'h00, 64'h0, 64'h0, 1'b0);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (bus.inst_rvalid !== 1'b0 || bus.data_rvalid !== 1'b0 || bus.mem_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got iv=%b dv=%b en=%b want 0 0 0", bus.inst_rvalid,
               bus.data_rvalid, bus.mem_en);
    end
    drive(1'b1, 64'h24, 1'b0, 8'h00, 64'h0, 64'h0, 1'b0);
    #1;
    checks++;
    if (bus.mem_en !== 1'b1 || bus.mem_addr !== 64'h20 || bus.stallreq_if !== 1'b0) begin
      errors++;
      $display("FAIL reset_comb got en=%b addr=%h sif=%b want 1 20 0", bus.mem_en,
               bus.mem_addr, bus.stallreq_if);
    end
    idle();
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mem_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle got en=%b want 0", bus.mem_en);
    end
  endtask

  task automatic test_fetch();
    @(posedge clk); #1;
    drive(1'b1, 64'h1004, 1'b0, 8'h00, 64'h0, 64'h0, 1'b0);
    push_inst(32'hAAAA_BBBB);
    @(negedge clk);
    checks++;
    if (bus.mem_en !== 1'b1 || bus.mem_addr !== 64'h1000 || bus.mem_we !== 8'h00 ||
        bus.stallreq_if !== 1'b0) begin
      errors++;
      $display("FAIL fetch_port got en=%b addr=%h we=%h sif=%b want 1 1000 00 0", bus.mem_en,
               bus.mem_addr, bus.mem_we, bus.stallreq_if);
    end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
  endtask

  task automatic test_collision();
    @(posedge clk); #1;
    drive(1'b1, 64'h48, 1'b1, 8'h00, 64'h10, 64'h0, 1'b0);
    push_data(pat(2));
    @(negedge clk);
    checks++;
    if (bus.mem_addr !== 64'h10 || bus.stallreq_if !== 1'b1 || bus.stallreq_ex !== 1'b0) begin
      errors++;
      $display("FAIL collision got addr=%h sif=%b sex=%b want 10 1 0", bus.mem_addr,
               bus.stallreq_if, bus.stallreq_ex);
    end
    // Fetch held, data gone: fetch granted back-to-back behind the load response.
    @(posedge clk); #1;
    drive(1'b1, 64'h48, 1'b0, 8'h00, 64'h0, 64'h0, 1'b0);
    push_inst(pat(9)[31:0]);
    @(negedge clk);
    checks++;
    if (bus.mem_addr !== 64'h48 || bus.stallreq_if !== 1'b0) begin
      errors++;
      $display("FAIL collision_fetch got addr=%h sif=%b want 48 0", bus.mem_addr,
               bus.stallreq_if);
    end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
  endtask

  task automatic test_starvation();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      drive(1'b1, 64'h0C, 1'b1, 8'h00, 64'((i < 4 ? i + 2 : 5) * 8), 64'h0, 1'b0);
      if (i == 4) push_inst(32'hC0DE_0001);
      else push_data(pat(i < 4 ? i + 2 : 5));
      @(negedge clk);
      checks++;
      if (i == 4) begin
        if (bus.mem_addr !== 64'h08 || bus.stallreq_ex !== 1'b1 || bus.stallreq_if !== 1'b0)
        begin
          errors++;
          $display("FAIL starve_force got addr=%h sex=%b sif=%b want 08 1 0", bus.mem_addr,
                   bus.stallreq_ex, bus.stallreq_if);
        end
      end else if (bus.mem_addr !== 64'((i < 4 ? i + 2 : 5) * 8) || bus.stallreq_if !== 1'b1 ||
                   bus.stallreq_ex !== 1'b0) begin
        errors++;
        $display("FAIL starve_data_%0d got addr=%h sif=%b sex=%b want data win", i,
                 bus.mem_addr, bus.stallreq_if, bus.stallreq_ex);
      end
    end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
  endtask

  task automatic test_store();
    @(posedge clk); #1;
    drive(1'b0, 64'h0, 1'b1, 8'hFF, 64'h30, 64'h1122_3344_5566_7788, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.mem_en !== 1'b1 || bus.mem_we !== 8'hFF || bus.mem_addr !== 64'h30 ||
        bus.mem_wdata !== 64'h1122_3344_5566_7788 || bus.stallreq_ex !== 1'b0) begin
      errors++;
      $display("FAIL store_port got en=%b we=%h addr=%h wd=%h want 1 ff 30 1122334455667788",
               bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    @(posedge clk); #1;
    drive(1'b0, 64'h0, 1'b1, 8'h00, 64'h30, 64'h0, 1'b0);
    push_data(64'h1122_3344_5566_7788);
    @(negedge clk);
    checks++;
    if (bus.data_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL store_no_resp got dv=%b want 0", bus.data_rvalid);
    end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    drive(1'b1, 64'h1004, 1'b0, 8'h00, 64'h0, 64'h0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 64'h08, 1'b0, 8'h00, 64'h0, 64'h0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.inst_rvalid !== 1'b0 || bus.mem_en !== 1'b0 || bus.stallreq_if !== 1'b0 ||
        bus.stallreq_ex !== 1'b0) begin
      errors++;
      $display("FAIL flush_kill got iv=%b en=%b sif=%b sex=%b want 0 0 0 0", bus.inst_rvalid,
               bus.mem_en, bus.stallreq_if, bus.stallreq_ex);
    end
    // Build up three losses, flush, then fetch must wait a full four losses again.
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      drive(1'b1, 64'h08, 1'b1, 8'h00, 64'h40, 64'h0, i == 3);
      if (i == 8) push_inst(32'h5EED_0001);
      else push_data(pat(8));
      @(negedge clk);
      checks++;
      if (i == 8) begin
        if (bus.mem_addr !== 64'h08 || bus.stallreq_ex !== 1'b1) begin
          errors++;
          $display("FAIL flush_starve_force got addr=%h sex=%b want 08 1", bus.mem_addr,
                   bus.stallreq_ex);
        end
      end else if (bus.mem_addr !== 64'h40 || bus.stallreq_if !== (i != 3) ||
                   bus.stallreq_ex !== 1'b0) begin
        errors++;
        $display("FAIL flush_starve_%0d got addr=%h sif=%b sex=%b want 40 %b 0", i,
                 bus.mem_addr, bus.stallreq_if, bus.stallreq_ex, i != 3);
      end
    end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    drive(1'b0, 64'h0, 1'b1, 8'h00, 64'h40, 64'h0, 1'b0);
    @(posedge clk); #1;
    idle();
    checks++;
    if (bus.data_rvalid !== 1'b1 || bus.data_rdata !== pat(8)) begin
      errors++;
      $display("FAIL areset_pre got dv=%b %h want 1 %h", bus.data_rvalid, bus.data_rdata,
               pat(8));
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.data_rvalid !== 1'b0 || bus.data_rdata !== 64'h0) begin
      errors++;
      $display("FAIL areset_drop got dv=%b %h want 0 0", bus.data_rvalid, bus.data_rdata);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mem_en !== 1'b0) begin
      errors++;
      $display("FAIL areset_idle got en=%b want 0", bus.mem_en);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    idle();
    test_reset();
    test_fetch();
    test_collision();
    test_starvation();
    test_store();
    test_flush();
    test_async_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (inst_q.size() != 0 || data_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got inst=%0d data=%0d pending want 0 0", inst_q.size(),
               data_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arb.md
# mem_port_arb

Arbiter and sequencer for the single-ported unified SRAM shared by instruction fetch and the EX-stage load/store port.
- Each cycle it grants the port to one requester and drives the memory port.
- It tracks which requester owns the one-cycle-latency read response, returns the data to that requester, and raises per-stage stall requests toward the pipeline controller for the requester that lost.
- Data accesses have priority; a starvation counter guarantees forward progress for fetch; a branch flush cancels in-flight fetch responses.

## Interface
- `STARVE_MAX`, default 4: consecutive fetch-loss cycles after which fetch is forced to win.
- `CNT_W`, default 3: width of the starvation counter; must hold `STARVE_MAX`.

Ports:
- `clk` in 1: the one clock; everything is rising-edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `inst_req` in 1: fetch request valid.
- `inst_addr` in 64: fetch byte address, 4-byte aligned.
- `inst_rdata` out 32: fetched instruction word.
- `inst_rvalid` out 1: `inst_rdata` valid this cycle.
- `data_sram_en` in 1: EX data access valid.
- `data_sram_we` in 8: byte write enables; 0 means read.
- `data_sram_addr` in 64: data address, 8-byte aligned word select.
- `data_sram_wdata` in 64: store data.
- `data_rdata` out 64: load data.
- `data_rvalid` out 1: `data_rdata` valid this cycle.
- `flush` in 1: branch taken in EX (`br_bus[64]`); cancels fetch.
- `mem_en` out 1: SRAM enable.
- `mem_we` out 8: SRAM byte write enables.
- `mem_addr` out 64: SRAM address.
- `mem_wdata` out 64: SRAM write data.
- `mem_rdata` in 64: SRAM read data, valid one cycle after `mem_en`.
- `stallreq_if` out 1: fetch denied this cycle.
- `stallreq_ex` out 1: data access denied this cycle.

## Operation

Grant logic (combinational in the request cycle):
- `force_inst` = (`starve_cnt` == `STARVE_MAX`).
- `grant_data` = `data_sram_en` & !(`force_inst` & `inst_req` & !`flush`).
- `grant_inst` = `inst_req` & !`flush` & !`grant_data`.
- A fetch presented in a `flush` cycle is never granted and causes no stall.

Memory port:
- On grant, the memory port carries the winner's signals: `mem_en`=1.
- Fetch grant drives `mem_we`=0 and `mem_addr`={`inst_addr`[63:3],3'b0}.
- Data grant drives `mem_we`/`mem_addr`/`mem_wdata` from `data_sram_*`.
- With no grant, `mem_en`=0 and all other `mem_*` outputs are 0.

Stall requests:
- `stallreq_if` = `inst_req` & !`flush` & !`grant_inst`.
- `stallreq_ex` = `data_sram_en` & !`grant_data`.
- Both are combinational.

Response owner register `owner_r` (NONE/INST/DATA) and `lane_r` (`inst_addr`[2]), loaded every cycle:
- INST if `grant_inst`.
- DATA if `grant_data` & (`data_sram_we`==0).
- Otherwise NONE. Stores are NONE: they produce no response.

Response cycle:
- `inst_rvalid` = (`owner_r`==INST) & !`flush`.
- `inst_rdata` = `lane_r` ? `mem_rdata`[63:32] : `mem_rdata`[31:0].
- `data_rvalid` = (`owner_r`==DATA).
- `data_rdata` = `mem_rdata`.
- When the matching `rvalid` is 0, `inst_rdata`/`data_rdata` are 0.
- A `flush` in the response cycle kills the fetch response; data responses are never killed.

Starvation counter `starve_cnt` (`CNT_W` bits):
- Cleared when `grant_inst`, when !`inst_req`, or when `flush`.
- Otherwise, if `inst_req` loses to data, it increments and saturates at `STARVE_MAX`.

## Timing
- Reset (async assert) values: `owner_r`=NONE, `lane_r`=0, `starve_cnt`=0. Consequently `inst_rvalid`=0 and `data_rvalid`=0 immediately.
- Combinational outputs follow their inputs during reset.
- Latency: request granted in cycle N produces `rvalid` in cycle N+1; back-to-back grants give one response per cycle.
- The requester must hold its request stable while its `stallreq_*` is high; the grant is taken in the first non-stalled cycle.
- Simultaneous requests:
  - data wins unless `force_inst`;
  - with `force_inst`, fetch wins, `stallreq_ex`=1 for exactly that cycle, and `starve_cnt` clears next edge.
- Maximum fetch wait under continuous data traffic is `STARVE_MAX` cycles; fetch wins in cycle `STARVE_MAX`+1.
- Reset asserted mid-response drops the pending response; no `rvalid` after reset release until a new grant.

## Test plan
- Fetch only: `inst_req`=1, `inst_addr`=0x1004, `mem_rdata`=0xAAAA_BBBB_CCCC_DDDD next cycle -> `mem_addr`=0x1000, then `inst_rvalid`=1 and `inst_rdata`=0xAAAABBBB.
- Load vs fetch collision: both valid, `starve_cnt`=0 -> data granted, `stallreq_if`=1, `stallreq_ex`=0; next cycle `data_rvalid`=1, `inst_rvalid`=0.
- Starvation with `STARVE_MAX`=4: `inst_req` and `data_sram_en` held high -> data wins 4 cycles, fetch wins cycle 5 with `stallreq_ex`=1, then data wins again.
- Store: `data_sram_we`=0xFF, `wdata`=0x1122334455667788 -> `mem_we`=0xFF and `mem_wdata` matches; next cycle `data_rvalid`=0.
- Flush: fetch granted in cycle N, `flush`=1 in N+1 -> `inst_rvalid`=0 in N+1, fetch in N+1 not granted, `stallreq_if`=0, `starve_cnt`=0.
- Async reset: assert `rst_n`=0 between clock edges with `owner_r`=DATA -> `data_rvalid` falls immediately; after release, idle port shows `mem_en`=0.
